// File: rtl/err_ctrl_pkg.sv
// rtl/err_ctrl_pkg.sv - shared state type and default sizes for the error frame controller
//
// Contents:
//   LEN_W_DEF, CNT_W_DEF, ALARM_TH_DEF : default parameter values for err_frame_ctrl
//   state_t                            : 3-bit frame sequencer state encoding
//   det_active()                       : true in the states where the detector runs
package err_ctrl_pkg;

    localparam int LEN_W_DEF    = 8;
    localparam int CNT_W_DEF    = 8;
    localparam int ALARM_TH_DEF = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    // The detector is out of reset, and its ERR output is meaningful, only
    // while bits are streaming (RUN) and for the one trailing cycle that
    // covers its output latency (DRAIN).
    function automatic logic det_active(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/err_sat_cnt.sv
// rtl/err_sat_cnt.sv - saturating event counter with synchronous clear
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset, count -> 0
//   clr    in   1      synchronous clear, has priority over inc
//   inc    in   1      add one unless already at all-ones
//   count  out  CNT_W  current count, sticks at 2^CNT_W-1
module err_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/err_frame_ctrl.sv
// rtl/err_frame_ctrl.sv - frames a serial stream for one Error_Detector and counts its ERR pulses
//
// Ports:
//   CLK        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      frame request, honoured only in IDLE
//   frame_len  in   LEN_W  frame length in bits, captured when start is accepted
//   Din_in     in   1      serial data from the source
//   clr        in   1      synchronous clear of err_count/alarm, aborts a running frame
//   err_in     in   1      ERR output of the detector
//   Din_out    out  1      serial data to the detector (Din_in during RUN, else 0)
//   det_rst    out  1      detector reset, low only in RUN and DRAIN
//   busy       out  1      a frame is in progress (state != IDLE)
//   done       out  1      one-cycle pulse in REPORT
//   err_count  out  CNT_W  saturating ERR count of the current/last frame
//   alarm      out  1      registered flag, err_count has reached ALARM_TH
//
// Build option:
//   ERR_STICKY_EN  when defined, alarm survives into later frames and is
//                  cleared only by clr or rst; otherwise starting a frame
//                  clears it so it reflects the current frame only.
//
// ALARM_TH must lie in 1 .. 2^CNT_W-1.
module err_frame_ctrl
    import err_ctrl_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ALARM_TH = ALARM_TH_DEF
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             Din_in,
    input  logic             clr,
    input  logic             err_in,
    output logic             Din_out,
    output logic             det_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] ALARM_TH_C = CNT_W'(ALARM_TH);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;

    logic start_ok;    // start accepted this cycle
    logic zero_start;  // accepted start of a zero-length frame
    logic last_bit;    // final RUN cycle of the frame
    logic frame_clr;   // a new frame begins: discard the previous count
    logic cnt_clr;
    logic cnt_inc;
    logic alarm_clr;

    // clr beats start in the same IDLE cycle.
    assign start_ok   = (state_q == IDLE) && start && !clr;
    assign zero_start = start_ok && (frame_len == '0);

    // len_q is never zero in RUN, so len_q-1 cannot underflow here.
    assign last_bit = (bit_cnt == (len_q - LEN_W'(1)));

    // A zero-length frame skips FLUSH, so it clears the count on acceptance
    // instead; REPORT then shows a count of 0.
    assign frame_clr = (state_q == FLUSH) || zero_start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (frame_len == '0) ? REPORT : FLUSH;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = clr ? IDLE : REPORT;
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        det_rst = 1'b1;
        Din_out = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            RUN: begin
                det_rst = 1'b0;
                Din_out = Din_in;
            end
            DRAIN: begin
                det_rst = 1'b0;
            end
            REPORT: begin
                done = 1'b1;
            end
            default: begin
                det_rst = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame length capture and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else if (start_ok) begin
            len_q <= frame_len;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state_q == FLUSH) begin
            bit_cnt <= '0;
        end else if (state_q == RUN) begin
            bit_cnt <= bit_cnt + LEN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // ERR counting
    // ------------------------------------------------------------------
    assign cnt_clr = clr || frame_clr;
    assign cnt_inc = err_in && det_active(state_q);

    err_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (CLK),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (err_count)
    );

    // ------------------------------------------------------------------
    // Alarm: registered off the counter output, so it rises one cycle after
    // the count reaches the threshold.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef ERR_STICKY_EN
        alarm_clr = clr;
`else
        alarm_clr = clr || frame_clr;
`endif
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end else if (err_count >= ALARM_TH_C) begin
            alarm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_err_frame_ctrl.sv
// tb/tb_err_frame_ctrl.sv - directed self-checking bench for err_frame_ctrl
module tb_err_frame_ctrl;

`ifdef ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] frame_len;
    logic       Din_in;
    logic       clr;
    logic       err_in;

    logic       Din_out, det_rst, busy, done, alarm;
    logic [7:0] err_count;
    logic       Din_out2, det_rst2, busy2, done2, alarm2;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    err_frame_ctrl dut (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .Din_in    (Din_in),
        .clr       (clr),
        .err_in    (err_in),
        .Din_out   (Din_out),
        .det_rst   (det_rst),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .alarm     (alarm)
    );

    err_frame_ctrl #(.CNT_W(2)) dut2 (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .Din_in    (Din_in),
        .clr       (clr),
        .err_in    (err_in),
        .Din_out   (Din_out2),
        .det_rst   (det_rst2),
        .busy      (busy2),
        .done      (done2),
        .err_count (err_count2),
        .alarm     (alarm2)
    );

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       din;
        logic       clr;
        logic       err;
        logic       e_det;
        logic       e_busy;
        logic       e_done;
        logic       e_dout;
        logic [7:0] e_cnt;
        logic       e_alarm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic [7:0] l, input logic d, input logic c,
                       input logic e, input logic x_det, input logic x_busy,
                       input logic x_done, input logic x_dout, input logic [7:0] x_cnt,
                       input logic x_alarm);
        vec_t v;
        v.start = s;  v.len = l;  v.din = d;  v.clr = c;  v.err = e;
        v.e_det = x_det;  v.e_busy = x_busy;  v.e_done = x_done;
        v.e_dout = x_dout;  v.e_cnt = x_cnt;  v.e_alarm = x_alarm;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [7:0] l, input logic d,
                          input logic c, input logic e);
        start = s;  frame_len = l;  Din_in = d;  clr = c;  err_in = e;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int r;
        int done_seen;
        int busy_seen;

        // ---------------- reset ----------------
        rst = 1'b1;
        set_in(0, 8'd0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset det_rst", det_rst, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err_count", err_count, 0);
        chk("reset alarm", alarm, 0);
        chk("reset Din_out", Din_out, 0);
        @(posedge CLK);
        #1;
        rst = 1'b0;

        // ---------------- vector table ----------------
        // Frame of 10 with two ERR pulses; frame_len changes mid-frame.
        add(1, 8'd10, 0, 0, 0, 1, 0, 0, 0, 8'd0, 0);
        add(0, 8'd10, 0, 0, 0, 1, 1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            logic       d;
            c = (i <= 2) ? 8'd0 : (i <= 5) ? 8'd1 : 8'd2;
            d = i[0];
            add(0, 8'd3, d, 0, (i == 2 || i == 5), 0, 1, 0, d, c, 0);
        end
        add(0, 8'd3, 1, 0, 0, 0, 1, 0, 0, 8'd2, 0);   // DRAIN gates data
        add(0, 8'd3, 0, 0, 1, 1, 1, 1, 0, 8'd2, 0);   // REPORT, err ignored
        add(0, 8'd3, 0, 0, 1, 1, 0, 0, 0, 8'd2, 0);   // IDLE holds count
        // Zero-length frame.
        add(1, 8'd0, 0, 0, 0, 1, 0, 0, 0, 8'd2, 0);
        add(0, 8'd0, 0, 0, 1, 1, 1, 1, 0, 8'd0, 0);
        add(0, 8'd0, 0, 0, 0, 1, 0, 0, 0, 8'd0, 0);
        // Frame of 8, ERR high for last two RUN cycles and DRAIN.
        add(1, 8'd8, 0, 0, 0, 1, 0, 0, 0, 8'd0, 0);
        add(0, 8'd8, 0, 0, 1, 1, 1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 8'd8, 1, 0, (i >= 6), 0, 1, 0, 1, (i == 7) ? 8'd1 : 8'd0, 0);
        end
        add(0, 8'd8, 1, 0, 1, 0, 1, 0, 0, 8'd2, 0);
        add(0, 8'd8, 0, 0, 0, 1, 1, 1, 0, 8'd3, 0);
        add(1, 8'd2, 0, 0, 0, 1, 0, 0, 0, 8'd3, 1);   // alarm one cycle after count
        add(0, 8'd2, 0, 0, 0, 1, 1, 0, 0, 8'd3, 1);
        add(0, 8'd2, 0, 0, 0, 0, 1, 0, 0, 8'd0, STICKY);
        add(0, 8'd2, 0, 0, 0, 0, 1, 0, 0, 8'd0, STICKY);
        add(0, 8'd2, 0, 0, 0, 0, 1, 0, 0, 8'd0, STICKY);
        add(0, 8'd2, 0, 0, 0, 1, 1, 1, 0, 8'd0, STICKY);
        add(0, 8'd2, 0, 0, 0, 1, 0, 0, 0, 8'd0, STICKY);

        for (int k = 0; k < tbl.size(); k++) begin
            set_in(tbl[k].start, tbl[k].len, tbl[k].din, tbl[k].clr, tbl[k].err);
            @(negedge CLK);
            chk($sformatf("row%0d det_rst", k), det_rst, tbl[k].e_det);
            chk($sformatf("row%0d busy", k), busy, tbl[k].e_busy);
            chk($sformatf("row%0d done", k), done, tbl[k].e_done);
            chk($sformatf("row%0d Din_out", k), Din_out, tbl[k].e_dout);
            chk($sformatf("row%0d err_count", k), err_count, tbl[k].e_cnt);
            chk($sformatf("row%0d alarm", k), alarm, tbl[k].e_alarm);
            step();
        end

        // ---------------- clr aborts RUN, start during RUN ignored ----------------
        set_in(1, 8'd20, 0, 0, 0);  step();   // IDLE -> FLUSH
        set_in(0, 8'd20, 0, 0, 0);  step();   // FLUSH -> RUN
        for (int i = 0; i < 4; i++) begin
            set_in(i == 2, (i == 2) ? 8'd5 : 8'd20, 1, 0, i < 3);
            step();
        end
        set_in(0, 8'd20, 1, 1, 0);
        @(negedge CLK);
        chk("abort pre busy", busy, 1);
        chk("abort pre det_rst", det_rst, 0);
        chk("abort pre err_count", err_count, 3);
        chk("abort pre alarm", alarm, 1);
        step();
        set_in(0, 8'd20, 0, 0, 0);
        @(negedge CLK);
        chk("abort busy", busy, 0);
        chk("abort det_rst", det_rst, 1);
        chk("abort done", done, 0);
        chk("abort err_count", err_count, 0);
        chk("abort alarm", alarm, 0);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        chk("abort no done", done_seen, 0);
        chk("abort no restart", busy_seen, 0);

        // ---------------- saturation with CNT_W=2 ----------------
        step();
        set_in(1, 8'd6, 0, 0, 0);  step();
        set_in(0, 8'd6, 0, 0, 1);  step();    // FLUSH, err ignored
        for (int i = 0; i < 6; i++) begin
            set_in(0, 8'd6, 1, 0, 1);
            step();
        end
        set_in(0, 8'd6, 0, 0, 0);  step();    // DRAIN
        @(negedge CLK);
        chk("sat done", done2, 1);
        chk("sat err_count2", err_count2, 3);
        chk("sat err_count", err_count, 6);
        chk("sat alarm2", alarm2, 1);

        // ---------------- rst mid-RUN ----------------
        step();
        step();
        set_in(1, 8'd20, 1, 0, 1);  step();
        set_in(0, 8'd20, 1, 0, 1);  step();
        for (int i = 0; i < 5; i++) step();
        chk("rst pre busy", busy, 1);
        chk("rst pre alarm", alarm, 1);
        chk("rst pre Din_out", Din_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async det_rst", det_rst, 1);
        chk("rst async busy", busy, 0);
        chk("rst async done", done, 0);
        chk("rst async Din_out", Din_out, 0);
        chk("rst async err_count", err_count, 0);
        chk("rst async alarm", alarm, 0);
        chk("rst async err_count2", err_count2, 0);
        set_in(0, 8'd0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        @(negedge CLK);
        chk("post rst busy", busy, 0);
        r = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
